// File: rtl/ifetch_prefetch_buffer_pkg.sv
// Shared defaults and the RVC length-detect helper for the instruction prefetch buffer.
package ifetch_prefetch_buffer_pkg;

  localparam int unsigned DEFAULT_DEPTH           = 4;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;
  localparam logic [31:0] DEFAULT_RESET_PC        = 32'h0000_0000;

  // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
  function automatic logic is_compressed(input logic [15:0] halfword);
    return halfword[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ifetch_prefetch_buffer_word_fifo.sv
// Circular word buffer exposing the head word and the word behind it, with flush.
module ifb_word_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   head,
  output logic [31:0]   next,
  output logic [CW-1:0] count
);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // DEPTH is a power of two, so the +1 index wraps naturally.
  assign head = mem[rd_ptr];
  assign next = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Prefetches aligned words ahead of decode and realigns mixed 16/32-bit instructions.
module ifetch_prefetch_buffer
  import ifetch_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH           = DEFAULT_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_compressed_o,
  input  logic        instr_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_addr;
  logic [31:0]   pc;
  logic          hoff;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_cnt;
  logic [CW-1:0] fifo_count;
  logic [31:0]   head_word;
  logic [31:0]   next_word;
  logic [31:0]   credit_sum;
  logic          granted;
  logic          rvalid_live;
  logic          fifo_push;
  logic          fifo_pop;
  logic          consume;
  logic [15:0]   cand;
  logic          cand_comp;

  // Handshakes: a request is accepted when imem_req_o && imem_gnt_i; an
  // instruction transfers when instr_valid_o && instr_ready_i. Neither
  // valid nor req depends on its own partner's ready/gnt.
  assign credit_sum  = 32'(fifo_count) + 32'(outstanding);
  assign imem_req_o  = !reset && !redirect_i && (credit_sum < DEPTH)
                       && (32'(outstanding) < MAX_OUTSTANDING);
  assign imem_addr_o = fetch_addr;
  assign granted     = imem_req_o && imem_gnt_i;
  // Responses with nothing outstanding are leftovers from before a reset.
  assign rvalid_live = imem_rvalid_i && (outstanding != '0);
  assign fifo_push   = rvalid_live && !redirect_i && (discard_cnt == '0);

  assign cand       = hoff ? head_word[31:16] : head_word[15:0];
  assign cand_comp  = is_compressed(cand);
  assign instr_pc_o = pc;

  always_comb begin
    instr_valid_o         = 1'b0;
    instr_o               = '0;
    instr_is_compressed_o = 1'b0;
    if (!redirect_i) begin
      if (cand_comp || !hoff) instr_valid_o = (fifo_count != '0);
      else                    instr_valid_o = (fifo_count >= CW'(2));
    end
    if (instr_valid_o) begin
      instr_is_compressed_o = cand_comp;
      if (cand_comp)  instr_o = {16'h0000, cand};
      else if (hoff)  instr_o = {next_word[15:0], head_word[31:16]};
      else            instr_o = head_word;
    end
  end

  assign consume  = instr_valid_o && instr_ready_i;
  // A head word retires once the instruction ending in its upper half is taken.
  assign fifo_pop = consume && (!cand_comp || hoff);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr  <= RESET_PC;
      pc          <= RESET_PC;
      hoff        <= 1'b0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + OW'(granted) - OW'(rvalid_live);
      if (redirect_i) begin
        fetch_addr  <= {redirect_pc_i[31:2], 2'b00};
        pc          <= {redirect_pc_i[31:1], 1'b0};
        hoff        <= redirect_pc_i[1];
        discard_cnt <= outstanding + OW'(granted) - OW'(rvalid_live);
      end else begin
        if (granted) fetch_addr <= fetch_addr + 32'd4;
        if (consume) begin
          pc   <= pc + (cand_comp ? 32'd2 : 32'd4);
          hoff <= hoff ^ cand_comp;
        end
        if (rvalid_live && (discard_cnt != '0)) discard_cnt <= discard_cnt - OW'(1);
      end
    end
  end

  ifb_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_i),
    .push      (fifo_push),
    .push_data (imem_rdata_i),
    .pop       (fifo_pop),
    .head      (head_word),
    .next      (next_word),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Bench for ifetch_prefetch_buffer: byte-stream reference model plus in-order memory model.
module tb_ifetch_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_compressed_o;
  logic        instr_ready_i = 1'b0;

  always #5 clk = ~clk;

  ifetch_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_is_compressed_o(instr_is_compressed_o), .instr_ready_i(instr_ready_i)
  );

  int vectors = 0;
  int miscompares = 0;

  // Memory image and in-flight requests (address plus stream tag).
  logic [31:0] mem [256];
  logic [31:0] pend_addr [$];
  int          pend_tag [$];

  // Reference model: the current stream starts at word address m_base; m_pc is
  // the next instruction; recv_words counts words of this stream delivered.
  int          stream = 0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_base = RESET_PC;
  int          recv_words = 0;
  int          gnt_words = 0;

  logic        exp_valid, exp_req, exp_comp;
  logic [31:0] exp_instr, exp_addr, exp_pc;

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // One clock: drive inputs at the falling edge, settle, compute expectations,
  // then advance the model to the state after the next rising edge.
  task automatic cycle(input bit rst, input bit gnt, input bit rv_ok, input bit ready,
                       input bit redir, input logic [31:0] rpc, input bit stale_rv);
    logic [15:0] h0;
    logic [31:0] off, a0;
    int          len;
    bit          rv;
    @(negedge clk);
    reset = rst; imem_gnt_i = gnt; instr_ready_i = ready;
    redirect_i = redir; redirect_pc_i = rpc;
    rv = (rv_ok && pend_addr.size() > 0) || stale_rv;
    imem_rvalid_i = rv;
    if (pend_addr.size() > 0) begin
      a0 = pend_addr[0];
      imem_rdata_i = mem[a0[9:2]];
    end else begin
      imem_rdata_i = $urandom;
    end
    #1;
    h0        = half_at(m_pc);
    off       = m_pc - m_base;
    exp_comp  = (h0[1:0] != 2'b11);
    len       = exp_comp ? 2 : 4;
    exp_valid = !redir && (int'(off) + len <= recv_words * 4);
    exp_instr = exp_comp ? {16'h0000, h0} : {half_at(m_pc + 32'd2), h0};
    exp_req   = !rst && !redir && (recv_words - int'(off >> 2) + pend_addr.size() < DEPTH)
                && (pend_addr.size() < MAX_OUT);
    exp_addr  = m_base + 32'(gnt_words * 4);
    exp_pc    = m_pc;
    if (rst) begin
      pend_addr.delete(); pend_tag.delete();
      stream++; m_pc = RESET_PC; m_base = RESET_PC; recv_words = 0; gnt_words = 0;
      return;
    end
    if (rv && pend_addr.size() > 0) begin
      if (pend_tag[0] == stream && !redir) recv_words++;
      void'(pend_addr.pop_front()); void'(pend_tag.pop_front());
    end
    if (exp_valid && ready) m_pc = m_pc + 32'(len);
    if (imem_req_o && gnt) begin
      pend_addr.push_back(imem_addr_o); pend_tag.push_back(stream);
    end
    if (exp_req && gnt) gnt_words++;
    if (redir) begin
      stream++; m_base = rpc & ~32'h3; m_pc = rpc & ~32'h1; recv_words = 0; gnt_words = 0;
    end
  endtask

  task automatic fill_mem(input logic [31:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 0, 0, 32'h0, 0);
      if (k > 0) begin
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got %0b want 0", imem_req_o); end
        vectors++; if (imem_addr_o !== RESET_PC) begin miscompares++; $display("FAIL reset_addr got %h want %h", imem_addr_o, RESET_PC); end
        vectors++; if (instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", instr_valid_o); end
        vectors++; if (instr_o !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", instr_o); end
        vectors++; if (instr_pc_o !== RESET_PC) begin miscompares++; $display("FAIL reset_pc got %h want %h", instr_pc_o, RESET_PC); end
        vectors++; if (instr_is_compressed_o !== 1'b0) begin miscompares++; $display("FAIL reset_comp got %0b want 0", instr_is_compressed_o); end
      end
    end
  endtask

  task automatic test_sequential();
    int hs = 0;
    fill_mem(32'h0000_0013);
    cycle(1, 0, 0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 1, 1, 0, 32'h0, 0);
      vectors++; if (instr_valid_o !== (k >= 2)) begin miscompares++; $display("FAIL seq_valid cycle %0d got %0b want %0b", k, instr_valid_o, k >= 2); end
      if (instr_valid_o === 1'b1 && hs < 4) begin
        vectors++;
        if (instr_o !== 32'h13 || instr_pc_o !== 32'(hs * 4) || instr_is_compressed_o !== 1'b0) begin
          miscompares++; $display("FAIL seq_instr %0d got %h@%h c%0b want 00000013@%h c0", hs, instr_o, instr_pc_o, instr_is_compressed_o, hs * 4);
        end
        hs++;
      end
    end
    vectors++; if (hs != 4) begin miscompares++; $display("FAIL seq_count got %0d want 4", hs); end
  endtask

  task automatic test_realign();
    logic [31:0] want_i [3] = '{32'h0000_0001, 32'h0013_0013, 32'h0000_0001};
    logic [31:0] want_p [3] = '{32'h0, 32'h2, 32'h6};
    logic        want_c [3] = '{1'b1, 1'b0, 1'b1};
    int hs = 0;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0013_0001; mem[1] = 32'h0001_0013; mem[2] = 32'h0001_0001;
    cycle(1, 0, 0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 1, 1, 0, 32'h0, 0);
      if (instr_valid_o === 1'b1 && hs < 3) begin
        vectors++;
        if (instr_o !== want_i[hs] || instr_pc_o !== want_p[hs] || instr_is_compressed_o !== want_c[hs]) begin
          miscompares++; $display("FAIL realign %0d got %h@%h c%0b want %h@%h c%0b", hs, instr_o, instr_pc_o, instr_is_compressed_o, want_i[hs], want_p[hs], want_c[hs]);
        end
        hs++;
      end
    end
    vectors++; if (hs != 3) begin miscompares++; $display("FAIL realign_count got %0d want 3", hs); end
  endtask

  task automatic test_redirect_drop();
    bit got_req = 0, got_hs = 0;
    fill_mem(32'h0000_0013);
    mem[64] = 32'h8082_0013;
    cycle(1, 0, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 1, 32'h102, 0);
    vectors++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL redir_quiet got req %0b valid %0b want 0 0", imem_req_o, instr_valid_o); end
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 1, 1, 0, 32'h0, 0);
      if (imem_req_o === 1'b1 && !got_req) begin
        got_req = 1;
        vectors++; if (imem_addr_o !== 32'h100) begin miscompares++; $display("FAIL redir_addr got %h want 00000100", imem_addr_o); end
      end
      if (instr_valid_o === 1'b1 && !got_hs) begin
        got_hs = 1;
        vectors++;
        if (instr_pc_o !== 32'h102 || instr_o !== 32'h0000_8082 || instr_is_compressed_o !== 1'b1) begin
          miscompares++; $display("FAIL redir_first got %h@%h c%0b want 00008082@00000102 c1", instr_o, instr_pc_o, instr_is_compressed_o);
        end
      end
    end
    vectors++; if (!(got_req && got_hs)) begin miscompares++; $display("FAIL redir_timeout got req %0b instr %0b want 1 1", got_req, got_hs); end
  endtask

  task automatic test_backpressure();
    fill_mem(32'h0000_0013);
    cycle(1, 0, 0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 1, 0, 0, 32'h0, 0);
      vectors++; if (imem_req_o !== exp_req) begin miscompares++; $display("FAIL bp_req cycle %0d got %0b want %0b", k, imem_req_o, exp_req); end
    end
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL bp_full_req got %0b want 0", imem_req_o); end
    cycle(0, 1, 1, 1, 0, 32'h0, 0);
    vectors++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_release got req %0b valid %0b want 0 1", imem_req_o, instr_valid_o); end
    cycle(0, 1, 1, 1, 0, 32'h0, 0);
    vectors++; if (imem_req_o !== 1'b1) begin miscompares++; $display("FAIL bp_resume got %0b want 1", imem_req_o); end
  endtask

  task automatic test_redirect_collide();
    bit got_hs = 0;
    fill_mem(32'h0000_0013);
    mem[0] = 32'hDEAD_BEEF; mem[1] = 32'hDEAD_BEEF;
    cycle(1, 0, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 1, 0, 1, 32'h40, 0);
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL collide_req got %0b want 0", imem_req_o); end
    for (int k = 0; k < 12; k++) begin
      cycle(0, 1, 1, 1, 0, 32'h0, 0);
      if (instr_valid_o === 1'b1) begin
        vectors++; if (instr_o === 32'hDEAD_BEEF) begin miscompares++; $display("FAIL collide_stale got %h want new-stream data", instr_o); end
        if (!got_hs) begin
          got_hs = 1;
          vectors++; if (instr_pc_o !== 32'h40) begin miscompares++; $display("FAIL collide_pc got %h want 00000040", instr_pc_o); end
        end
      end
    end
    vectors++; if (!got_hs) begin miscompares++; $display("FAIL collide_timeout got no instruction want one"); end
    vectors++; if (dut.discard_cnt !== '0) begin miscompares++; $display("FAIL collide_discard got %0d want 0", dut.discard_cnt); end
  endtask

  task automatic test_reset_midflight();
    bit got_hs = 0;
    fill_mem(32'h0000_0013);
    cycle(1, 0, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 0, 32'h0, 0);
    cycle(1, 0, 0, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin miscompares++; $display("FAIL rst_mid_req got %0b@%h want 1@%h", imem_req_o, imem_addr_o, RESET_PC); end
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    vectors++; if (instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stale got valid %0b want 0", instr_valid_o); end
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 1, 1, 0, 32'h0, 0);
      if (instr_valid_o === 1'b1 && !got_hs) begin
        got_hs = 1;
        vectors++; if (instr_pc_o !== RESET_PC || instr_o !== 32'h13) begin miscompares++; $display("FAIL rst_mid_first got %h@%h want 00000013@%h", instr_o, instr_pc_o, RESET_PC); end
      end
    end
    vectors++; if (!got_hs) begin miscompares++; $display("FAIL rst_mid_timeout got no instruction want one"); end
  endtask

  task automatic test_random();
    bit          g, rv, rdy, redir;
    logic [31:0] rpc;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    cycle(1, 0, 0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 4000; k++) begin
      g     = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 2) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 29) == 0);
      rpc   = $urandom_range(0, 1) ? ($urandom & 32'h0000_03FE) : (32'hFFFF_FFE0 | ($urandom & 32'h1E));
      cycle(0, g, rv, rdy, redir, rpc, 0);
      vectors++; if (imem_req_o !== exp_req) begin miscompares++; $display("FAIL rnd_req cycle %0d got %0b want %0b", k, imem_req_o, exp_req); end
      vectors++; if (imem_addr_o !== exp_addr) begin miscompares++; $display("FAIL rnd_addr cycle %0d got %h want %h", k, imem_addr_o, exp_addr); end
      vectors++; if (instr_valid_o !== exp_valid) begin miscompares++; $display("FAIL rnd_valid cycle %0d got %0b want %0b", k, instr_valid_o, exp_valid); end
      vectors++; if (instr_pc_o !== exp_pc) begin miscompares++; $display("FAIL rnd_pc cycle %0d got %h want %h", k, instr_pc_o, exp_pc); end
      if (exp_valid) begin
        vectors++;
        if (instr_o !== exp_instr || instr_is_compressed_o !== exp_comp) begin
          miscompares++; $display("FAIL rnd_instr cycle %0d got %h c%0b want %h c%0b", k, instr_o, instr_is_compressed_o, exp_instr, exp_comp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_realign();
    test_redirect_drop();
    test_backpressure();
    test_redirect_collide();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
